// File: rtl/dot_acc_pkg.sv
// Shared types and sizing helpers for the dot-product accumulator.
// The accumulator width is derived so LEN full-scale products can never
// overflow, which is why the datapath carries no wrap or saturate logic.
package dot_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DEFAULT_LEN   = 4;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_LEN + 1);

    // Product width plus enough headroom bits for LEN summed products
    function automatic int acc_width(input int n, input int m, input int len);
        return n + m + $clog2(len);
    endfunction

    // Width able to hold the count values 0..len inclusive
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/dot_beat_counter.sv
// Modulo-LEN beat counter. last_beat flags that the next increment is the
// LEN-th beat of the current dot product; clr restarts the count at zero and
// wins over inc so an early termination or abort always starts a fresh run.
module dot_beat_counter
    import dot_acc_pkg::*;
#(
    parameter int LEN   = DEFAULT_LEN,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last_beat
);

    assign last_beat = (cnt == CNT_W'(LEN - 1));

    // Count accepted beats, wrapping to zero after the LEN-th one
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (last_beat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Serial dot-product accumulator placed after an N x M array multiplier.
// Sums LEN consecutive accepted products and holds the result on a
// valid/ready port until the consumer takes it; no beats are accepted while
// a result is pending. clr aborts any partial or pending result.
// Optional macro DOT_EARLY_LAST_EN adds an in_last input that can close a
// dot product before LEN beats have been taken.
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int M     = 4,
    parameter  int LEN   = 4,
    localparam int ACC_W = acc_width(N, M, LEN),
    localparam int CNT_W = cnt_width(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+M-1:0]   in_prod,
`ifdef DOT_EARLY_LAST_EN
    input  logic             in_last,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             finish;
    logic             early_last;
    logic             last_beat;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

`ifdef DOT_EARLY_LAST_EN
    assign early_last = in_last;
`else
    assign early_last = 1'b0;
`endif

    assign in_ready  = (state == ACCUM) && !clr;
    assign accept    = in_valid && in_ready;
    assign finish    = accept && (last_beat || early_last);
    assign acc_next  = acc + ACC_W'(in_prod);
    assign cnt_clr   = clr || finish;
    assign out_valid = (state == DONE);

    dot_beat_counter #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept),
        .clr       (cnt_clr),
        .cnt       (cnt),
        .last_beat (last_beat)
    );

    // State register; reset returns to collecting products
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next state: clr overrides everything, otherwise finish or handshake advance
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = ACCUM;
        end else begin
            case (state)
                ACCUM: begin
                    if (finish) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        next_state = ACCUM;
                    end
                end
                default: next_state = ACCUM;
            endcase
        end
    end

    // Accumulate accepted products and capture the result on the closing beat
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (accept) begin
            if (finish) begin
                out_sum <= acc_next;
                out_cnt <= cnt + CNT_W'(1);
                acc     <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
// Build with +define+DOT_EARLY_LAST_EN to also exercise in_last.
module tb_dot_product_accumulator;

    localparam int N     = 4;
    localparam int M     = 4;
    localparam int LEN   = 4;
    localparam int ACC_W = N + M + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [N+M-1:0]   in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: products of the dot product in progress, and the
    // result currently offered to the consumer
    int m_prods[$];
    bit m_done;
    int m_sum;
    int m_cnt;

    dot_product_accumulator #(
        .N   (N),
        .M   (M),
        .LEN (LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
`ifdef DOT_EARLY_LAST_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge
    task automatic modelStep(input bit v, input int p, input bit l, input bit ordy,
                             input bit c, input bit r);
        if (r) begin
            m_prods.delete();
            m_done = 0;
            m_sum  = 0;
            m_cnt  = 0;
        end else if (c) begin
            m_prods.delete();
            m_done = 0;
        end else if (m_done) begin
            if (ordy) m_done = 0;
        end else if (v) begin
            m_prods.push_back(p);
            if (m_prods.size() == LEN || l) begin
                m_sum  = m_prods.sum();
                m_cnt  = m_prods.size();
                m_prods.delete();
                m_done = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, then step it
    task automatic applyStimulus(input bit v, input int p, input bit l, input bit ordy,
                                 input bit c, input bit r);
        logic [31:0] pv;
        pv = p;
        @(negedge clk);
        in_valid  = v;
        in_prod   = pv[N+M-1:0];
        in_last   = l;
        out_ready = ordy;
        clr       = c;
        rst       = r;
        #1;
        checkOutput("out_valid", int'(out_valid), int'(m_done));
        checkOutput("in_ready", int'(in_ready), int'(!m_done && !c));
        checkOutput("out_sum", int'(out_sum), m_sum);
        checkOutput("out_cnt", int'(out_cnt), m_cnt);
        modelStep(v, p, l, ordy, c, r);
    endtask

    // Check fixed values just after the next rising edge
    task automatic expectNow(input string tag, input int valid, input int sum, input int cnt);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, int'(out_valid), valid);
        checkOutput({tag, "_sum"}, int'(out_sum), sum);
        checkOutput({tag, "_cnt"}, int'(out_cnt), cnt);
        if (valid != 0) checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_done    = 0;
        m_sum     = 0;
        m_cnt     = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_sum", int'(out_sum), 0);
        checkOutput("reset_cnt", int'(out_cnt), 0);
        modelStep(0, 0, 0, 0, 0, 1);

        $display("[TB] full-scale products");
        repeat (4) applyStimulus(1, 225, 0, 1, 0, 0);
        expectNow("t1", 1, 900, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] back-pressure hold");
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 0, 0, 0);
        expectNow("t2_hold", 1, 10, 4);
        repeat (5) applyStimulus(1, 99, 0, 0, 0, 0);
        applyStimulus(1, 99, 0, 1, 0, 0);
        repeat (4) applyStimulus(1, 1, 0, 1, 0, 0);
        expectNow("t2_next", 1, 4, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] gapped input");
        for (int i = 0; i < 7; i++) applyStimulus(i % 2 == 0, 10 * (i / 2 + 1), 0, 1, 0, 0);
        expectNow("t3", 1, 100, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] clear handling");
        repeat (2) applyStimulus(1, 5, 0, 1, 0, 0);
        applyStimulus(1, 9, 0, 1, 1, 0);
        repeat (4) applyStimulus(1, 1, 0, 1, 0, 0);
        expectNow("t4", 1, 4, 4);
        applyStimulus(0, 0, 0, 1, 1, 0);
        expectNow("t4_drop", 0, 4, 4);

        $display("[TB] reset mid-accumulation");
        repeat (2) applyStimulus(1, 3, 0, 1, 0, 0);
        applyStimulus(1, 3, 0, 1, 0, 1);
        expectNow("t5_rst", 0, 0, 0);
        repeat (4) applyStimulus(1, 7, 0, 1, 0, 0);
        expectNow("t5", 1, 28, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);

`ifdef DOT_EARLY_LAST_EN
        $display("[TB] early last");
        applyStimulus(1, 3, 0, 1, 0, 0);
        applyStimulus(1, 4, 1, 1, 0, 0);
        expectNow("t6_early", 1, 7, 2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        repeat (4) applyStimulus(1, 225, 0, 1, 0, 0);
        expectNow("t6_full", 1, 900, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 2, i == 3, 1, 0, 0);
        expectNow("t6_last_on_len", 1, 8, 4);
        applyStimulus(0, 0, 0, 1, 0, 0);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bit v, l, o, c, r;
            int p;
            v = 1'($urandom_range(0, 3) != 0);
            p = int'($urandom_range(0, 225));
            o = 1'($urandom_range(0, 2) != 0);
            c = 1'($urandom_range(0, 24) == 0);
            r = 1'($urandom_range(0, 99) == 0);
`ifdef DOT_EARLY_LAST_EN
            l = 1'($urandom_range(0, 5) == 0);
`else
            l = 1'b0;
`endif
            applyStimulus(v, p, l, o, c, r);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
